// File: rtl/scara_joint_sequencer.sv
// scara_joint_sequencer
//   Queues joint-space move commands, resolves absolute/relative targets
//   against the committed joint positions, and feeds the stepper drivers
//   with bursts of at most 2^STEP_W-1 steps per joint over valid/ready.
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   cmd_valid/ready   command handshake (ready = queue not full)
//   cmd_target        per-joint target or signed offset, ANGLE_W each
//   cmd_relative      target is an offset from the current position
//   cmd_pen           requested end-effector state for the move
//   cmd_dwell         extra idle cycles after the move completes
//   step_valid/ready  burst handshake towards the stepper drivers
//   step_count        per-joint burst magnitude, STEP_W each
//   step_dir          per-joint direction, 1 = positive
//   pen_state         current end-effector state
//   position          committed joint positions, ANGLE_W each
//   busy              sequencer active or commands pending
//   move_done         one-cycle pulse when a command retires
module scara_joint_sequencer #(
  parameter int unsigned NUM_JOINTS = 2,
  parameter int unsigned ANGLE_W    = 13,
  parameter int unsigned STEP_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned HOME_POS   = 402,
  parameter int unsigned PEN_DWELL  = 200,
  parameter int unsigned DWELL_W    = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic [NUM_JOINTS*ANGLE_W-1:0]   cmd_target,
  input  logic                            cmd_relative,
  input  logic                            cmd_pen,
  input  logic [DWELL_W-1:0]              cmd_dwell,
  output logic                            step_valid,
  input  logic                            step_ready,
  output logic [NUM_JOINTS*STEP_W-1:0]    step_count,
  output logic [NUM_JOINTS-1:0]           step_dir,
  output logic                            pen_state,
  output logic [NUM_JOINTS*ANGLE_W-1:0]   position,
  output logic                            busy,
  output logic                            move_done
);

  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned TGT_W   = NUM_JOINTS * ANGLE_W;
  localparam int unsigned ENTRY_W = TGT_W + 2 + DWELL_W;
  localparam int unsigned PEN_W   = $clog2(PEN_DWELL + 1);
  localparam int unsigned TMR_W   = (DWELL_W > PEN_W) ? DWELL_W : PEN_W;

  localparam logic [ANGLE_W-1:0] BURST_MAX = ANGLE_W'((1 << STEP_W) - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD     = 3'd1;
  localparam logic [2:0] S_PEN_WAIT = 3'd2;
  localparam logic [2:0] S_CALC     = 3'd3;
  localparam logic [2:0] S_ISSUE    = 3'd4;
  localparam logic [2:0] S_GAP      = 3'd5;
  localparam logic [2:0] S_DWELL    = 3'd6;

  // ---------------------------------------------------------------- FIFO
  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wptr_q, rptr_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ready_q;
  logic               push, pop;

  logic [2:0]         state_q, state_d;

  assign push      = cmd_valid & ready_q;
  assign pop       = (state_q == S_LOAD);
  assign count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
  assign cmd_ready = ready_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {cmd_dwell, cmd_pen, cmd_relative, cmd_target};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ready_q <= 1'b1;
    end else begin
      if (push) wptr_q <= wptr_q + PTR_W'(1);
      if (pop)  rptr_q <= rptr_q + PTR_W'(1);
      count_q <= count_d;
      ready_q <= (count_d != CNT_W'(FIFO_DEPTH));
    end
  end

  logic [ENTRY_W-1:0] head;
  logic [TGT_W-1:0]   head_tgt;
  logic               head_rel, head_pen;
  logic [DWELL_W-1:0] head_dwell;

  assign head       = mem_q[rptr_q];
  assign head_tgt   = head[TGT_W-1:0];
  assign head_rel   = head[TGT_W];
  assign head_pen   = head[TGT_W+1];
  assign head_dwell = head[ENTRY_W-1 -: DWELL_W];

  // ----------------------------------------------------------- datapath
  logic [ANGLE_W-1:0] pos_q [NUM_JOINTS];
  logic [ANGLE_W-1:0] pos_d [NUM_JOINTS];
  logic [ANGLE_W-1:0] tgt_q [NUM_JOINTS];
  logic [ANGLE_W-1:0] tgt_d [NUM_JOINTS];
  logic [ANGLE_W-1:0] mag_q [NUM_JOINTS];
  logic [ANGLE_W-1:0] mag_d [NUM_JOINTS];
  logic [NUM_JOINTS-1:0] dir_q, dir_d;
  logic [ANGLE_W-1:0] rem     [NUM_JOINTS];
  logic [ANGLE_W-1:0] mag_new [NUM_JOINTS];
  logic [STEP_W-1:0]  burst   [NUM_JOINTS];
  logic               any_new_nz, any_mag_nz;

  logic               pen_q, pen_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               pen_last, dwell_last;

  // Magnitude is kept unsigned ANGLE_W wide so the most negative
  // remainder maps to 2^(ANGLE_W-1) instead of overflowing.
  always_comb begin
    any_new_nz = 1'b0;
    any_mag_nz = 1'b0;
    for (int unsigned j = 0; j < NUM_JOINTS; j++) begin
      rem[j]     = tgt_q[j] - pos_q[j];
      mag_new[j] = rem[j][ANGLE_W-1] ? ('0 - rem[j]) : rem[j];
      burst[j]   = (mag_q[j] > BURST_MAX) ? '1 : mag_q[j][STEP_W-1:0];
      any_new_nz = any_new_nz | (mag_new[j] != '0);
      any_mag_nz = any_mag_nz | (mag_q[j] != '0);
    end
  end

  assign pen_last   = (32'(tmr_q) + 32'd1) >= 32'(PEN_DWELL);
  assign dwell_last = (tmr_q == TMR_W'(dwell_q));

  // ---------------------------------------------------------------- FSM
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    pen_d   = pen_q;
    dwell_d = dwell_q;
    dir_d   = dir_q;
    for (int unsigned j = 0; j < NUM_JOINTS; j++) begin
      pos_d[j] = pos_q[j];
      tgt_d[j] = tgt_q[j];
      mag_d[j] = mag_q[j];
    end
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) state_d = S_LOAD;
      end
      S_LOAD: begin
        for (int unsigned j = 0; j < NUM_JOINTS; j++) begin
          tgt_d[j] = head_rel ? pos_q[j] + head_tgt[j*ANGLE_W +: ANGLE_W]
                              : head_tgt[j*ANGLE_W +: ANGLE_W];
        end
        dwell_d = head_dwell;
        tmr_d   = '0;
        if (head_pen != pen_q) begin
          pen_d   = head_pen;
          state_d = S_PEN_WAIT;
        end else begin
          state_d = S_CALC;
        end
      end
      S_PEN_WAIT: begin
        if (pen_last) state_d = S_CALC;
        else          tmr_d   = tmr_q + TMR_W'(1);
      end
      S_CALC: begin
        tmr_d = '0;
        for (int unsigned j = 0; j < NUM_JOINTS; j++) begin
          mag_d[j] = mag_new[j];
          // idle joints keep the direction of their last real move
          if (mag_new[j] != '0) dir_d[j] = ~rem[j][ANGLE_W-1];
        end
        state_d = any_new_nz ? S_ISSUE : S_DWELL;
      end
      S_ISSUE: begin
        if (step_ready) begin
          for (int unsigned j = 0; j < NUM_JOINTS; j++) begin
            pos_d[j] = dir_q[j] ? pos_q[j] + ANGLE_W'(burst[j])
                                : pos_q[j] - ANGLE_W'(burst[j]);
            mag_d[j] = mag_q[j] - ANGLE_W'(burst[j]);
          end
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        state_d = any_mag_nz ? S_ISSUE : S_DWELL;
      end
      S_DWELL: begin
        // the final DWELL cycle is the move_done cycle
        if (dwell_last) state_d = S_IDLE;
        else            tmr_d   = tmr_q + TMR_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      pen_q   <= 1'b0;
      dwell_q <= '0;
      dir_q   <= '0;
      for (int unsigned j = 0; j < NUM_JOINTS; j++) begin
        pos_q[j] <= ANGLE_W'(HOME_POS);
        tgt_q[j] <= ANGLE_W'(HOME_POS);
        mag_q[j] <= '0;
      end
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      pen_q   <= pen_d;
      dwell_q <= dwell_d;
      dir_q   <= dir_d;
      for (int unsigned j = 0; j < NUM_JOINTS; j++) begin
        pos_q[j] <= pos_d[j];
        tgt_q[j] <= tgt_d[j];
        mag_q[j] <= mag_d[j];
      end
    end
  end

  // ------------------------------------------------------------- outputs
  always_comb begin
    for (int unsigned j = 0; j < NUM_JOINTS; j++) begin
      step_count[j*STEP_W +: STEP_W]  = burst[j];
      position[j*ANGLE_W +: ANGLE_W]  = pos_q[j];
    end
  end

  assign step_dir   = dir_q;
  assign step_valid = (state_q == S_ISSUE);
  assign pen_state  = pen_q;
  assign busy       = (state_q != S_IDLE) || (count_q != '0);
  assign move_done  = (state_q == S_DWELL) && dwell_last;

endmodule

// File: tb/tb_scara_joint_sequencer.sv
module tb_scara_joint_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [25:0] cmd_target;
  logic        cmd_relative;
  logic        cmd_pen;
  logic [15:0] cmd_dwell;
  logic        step_valid;
  logic        step_ready;
  logic [15:0] step_count;
  logic [1:0]  step_dir;
  logic        pen_state;
  logic [25:0] position;
  logic        busy;
  logic        move_done;

  scara_joint_sequencer #(
    .NUM_JOINTS(2), .ANGLE_W(13), .STEP_W(8), .FIFO_DEPTH(4),
    .HOME_POS(402), .PEN_DWELL(200), .DWELL_W(16)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_target(cmd_target),
    .cmd_relative(cmd_relative), .cmd_pen(cmd_pen), .cmd_dwell(cmd_dwell),
    .step_valid(step_valid), .step_ready(step_ready), .step_count(step_count),
    .step_dir(step_dir), .pen_state(pen_state), .position(position),
    .busy(busy), .move_done(move_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] c0;
    logic [7:0] c1;
    logic       d0;
    logic       d1;
  } burst_t;

  burst_t      exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          done_cnt = 0;
  int          exp_done = 0;
  bit          mon_en = 1'b0;
  logic [12:0] m_pos [2];
  logic [1:0]  m_dir;
  logic        m_pen;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: resolve the target, then split the move into bursts.
  task automatic model_cmd(input logic [12:0] t0, input logic [12:0] t1,
                           input logic rel, input logic pen);
    logic [12:0] t [2];
    logic [12:0] mag [2];
    logic [12:0] tgt, rem;
    logic [7:0]  c [2];
    burst_t      b;
    t[0] = t0;
    t[1] = t1;
    for (int j = 0; j < 2; j++) begin
      tgt    = rel ? m_pos[j] + t[j] : t[j];
      rem    = tgt - m_pos[j];
      mag[j] = rem[12] ? 13'd0 - rem : rem;
      if (mag[j] != 13'd0) m_dir[j] = ~rem[12];
    end
    while (mag[0] != 13'd0 || mag[1] != 13'd0) begin
      for (int j = 0; j < 2; j++) begin
        c[j] = (mag[j] > 13'd255) ? 8'd255 : mag[j][7:0];
        m_pos[j] = m_dir[j] ? m_pos[j] + {5'd0, c[j]} : m_pos[j] - {5'd0, c[j]};
        mag[j] = mag[j] - {5'd0, c[j]};
      end
      b.c0 = c[0];
      b.c1 = c[1];
      b.d0 = m_dir[0];
      b.d1 = m_dir[1];
      exp_q.push_back(b);
    end
    m_pen = pen;
    exp_done++;
  endtask

  task automatic model_reset();
    m_pos[0] = 13'd402;
    m_pos[1] = 13'd402;
    m_dir    = 2'b00;
    m_pen    = 1'b0;
    exp_q.delete();
    done_cnt = 0;
    exp_done = 0;
  endtask

  // Burst scoreboard: every offered burst is compared with the queue head;
  // the head retires on handshake.
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (move_done) done_cnt++;
      if (step_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_burst", {31'd0, step_valid}, 32'd0);
        end else begin
          check_eq("count0", {24'd0, step_count[7:0]},  {24'd0, exp_q[0].c0});
          check_eq("count1", {24'd0, step_count[15:8]}, {24'd0, exp_q[0].c1});
          check_eq("dir",    {30'd0, step_dir}, {30'd0, exp_q[0].d1, exp_q[0].d0});
          if (step_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic push_cmd(input logic [12:0] t0, input logic [12:0] t1,
                          input logic rel, input logic pen, input logic [15:0] dw);
    int n;
    @(negedge clk);
    cmd_valid    = 1'b1;
    cmd_target   = {t1, t0};
    cmd_relative = rel;
    cmd_pen      = pen;
    cmd_dwell    = dw;
    n = 0;
    while (!cmd_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      check_eq("cmd_ready_timeout", {31'd0, cmd_ready}, 32'd1);
    end else begin
      @(posedge clk);
      model_cmd(t0, t1, rel, pen);
    end
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done_cnt != exp_done && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check_eq("done_count", done_cnt, exp_done);
  endtask

  task automatic check_pos(input string tag);
    check_eq({tag, "_pos0"}, {19'd0, position[12:0]},  {19'd0, m_pos[0]});
    check_eq({tag, "_pos1"}, {19'd0, position[25:13]}, {19'd0, m_pos[1]});
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          lat;
    int          low;
    logic [12:0] save_pos [2];

    reset        = 1'b1;
    cmd_valid    = 1'b0;
    cmd_target   = '0;
    cmd_relative = 1'b0;
    cmd_pen      = 1'b0;
    cmd_dwell    = '0;
    step_ready   = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // reset state
    @(negedge clk);
    check_pos("reset");
    check_eq("reset_pen",   {31'd0, pen_state},  32'd0);
    check_eq("reset_ready", {31'd0, cmd_ready},  32'd1);
    check_eq("reset_valid", {31'd0, step_valid}, 32'd0);
    check_eq("reset_busy",  {31'd0, busy},       32'd0);
    check_eq("reset_count", {16'd0, step_count}, 32'd0);
    check_eq("reset_done",  {31'd0, move_done},  32'd0);
    mon_en = 1'b1;

    // absolute move in three bursts; IDLE, LOAD, CALC then ISSUE
    push_cmd(13'd1002, 13'd392, 1'b0, 1'b0, 16'd0);
    lat = 0;
    @(negedge clk);
    while (!step_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check_eq("issue_latency", lat, 3);
    wait_done();
    check_pos("abs");
    check_eq("abs_queue_empty", exp_q.size(), 0);

    // relative move with pen change: PEN_WAIT (200) + CALC before the burst
    do_reset();
    mon_en = 1'b1;
    push_cmd(13'h1FFB, 13'd3, 1'b1, 1'b1, 16'd0);
    lat = 0;
    while (!pen_state && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check_eq("pen_rise", {31'd0, pen_state}, 32'd1);
    low = 0;
    while (!step_valid && low < 400) begin
      low++;
      @(negedge clk);
    end
    check_eq("pen_wait_cycles", low, 201);
    wait_done();
    check_pos("rel");
    check_eq("rel_pen", {31'd0, pen_state}, {31'd0, m_pen});

    // zero-length move with dwell 10: CALC at 2, DWELL 3..12, done at 13
    push_cmd(m_pos[0], m_pos[1], 1'b0, 1'b1, 16'd10);
    lat = 0;
    @(negedge clk);
    while (!move_done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check_eq("dwell_done_latency", lat, 13);
    wait_done();
    check_pos("dwell");

    // back-to-back commands into a stalled stepper: queue fills
    save_pos[0] = m_pos[0];
    save_pos[1] = m_pos[1];
    @(posedge clk);
    #1 step_ready = 1'b0;
    push_cmd(13'd500,  13'd300,  1'b0, 1'b1, 16'd0);
    push_cmd(13'd700,  13'd300,  1'b0, 1'b1, 16'd0);
    push_cmd(13'd100,  13'h1FCE, 1'b1, 1'b1, 16'd2);
    push_cmd(13'd8000, 13'd10,   1'b0, 1'b1, 16'd0);
    push_cmd(13'd4096, 13'd0,    1'b1, 1'b0, 16'd0);
    check_eq("full_ready", {31'd0, cmd_ready}, 32'd0);
    check_eq("full_busy",  {31'd0, busy},      32'd1);
    repeat (20) @(negedge clk);
    check_eq("stall_valid", {31'd0, step_valid}, 32'd1);
    check_eq("stall_pos0", {19'd0, position[12:0]},  {19'd0, save_pos[0]});
    check_eq("stall_pos1", {19'd0, position[25:13]}, {19'd0, save_pos[1]});
    check_eq("stall_ready", {31'd0, cmd_ready}, 32'd0);
    @(posedge clk);
    #1 step_ready = 1'b1;
    wait_done();
    check_pos("queue");
    check_eq("queue_pen",   {31'd0, pen_state}, {31'd0, m_pen});
    check_eq("queue_empty", exp_q.size(), 0);
    @(negedge clk);
    check_eq("queue_idle_busy", {31'd0, busy}, 32'd0);

    // reset in the middle of a burst with commands queued
    @(posedge clk);
    #1 step_ready = 1'b0;
    push_cmd(13'd1000, 13'd1000, 1'b0, 1'b0, 16'd0);
    push_cmd(13'd2000, 13'd2000, 1'b0, 1'b0, 16'd0);
    push_cmd(13'd3000, 13'd3000, 1'b0, 1'b0, 16'd0);
    lat = 0;
    while (!step_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check_eq("pre_reset_valid", {31'd0, step_valid}, 32'd1);
    do_reset();
    check_eq("rst_valid", {31'd0, step_valid}, 32'd0);
    check_eq("rst_ready", {31'd0, cmd_ready},  32'd1);
    check_eq("rst_busy",  {31'd0, busy},       32'd0);
    check_eq("rst_done",  {31'd0, move_done},  32'd0);
    check_eq("rst_pen",   {31'd0, pen_state},  32'd0);
    check_pos("rst");
    mon_en = 1'b1;
    #1 step_ready = 1'b1;
    repeat (30) @(negedge clk);
    check_eq("rst_no_done", done_cnt, exp_done);

    // sequencer still works after the mid-move reset
    push_cmd(13'd410, 13'd400, 1'b0, 1'b0, 16'd0);
    wait_done();
    check_pos("post_rst");
    check_eq("post_rst_queue", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
